// File: rtl/clusterv_tile_pkg.sv
// Shared definitions for the clusterv tile Wishbone-to-SRAM bridge:
// FSM state type, default geometry and byte-lane helper.
package clusterv_tile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } wb2sram_state_e;

    localparam int unsigned DEF_SRAM_ADR_WIDTH = 8;
    localparam int unsigned DEF_DAT_WIDTH      = 32;

    function automatic int unsigned byte_lanes(input int unsigned dat_width);
        return dat_width / 8;
    endfunction

endpackage

// File: rtl/clusterv_tile_wb2sram.sv
// Wishbone classic target to tile SRAM byte-enable initiator bridge.
// One SRAM access per Wishbone cycle: write acks 2 clocks after stb is
// sampled, read acks 3 clocks after (one-cycle SRAM read latency).
// Optional macro CLUSTERV_TILE_WB2SRAM_ERR_EN: decode wb_adr against the
// SRAM window at BASE_ADR and answer out-of-window cycles with wb_err.
module clusterv_tile_wb2sram
    import clusterv_tile_pkg::*;
#(
    parameter int unsigned WB_ADR_WIDTH   = 32,
    parameter int unsigned SRAM_ADR_WIDTH = DEF_SRAM_ADR_WIDTH,
    parameter int unsigned DAT_WIDTH      = DEF_DAT_WIDTH,
    parameter logic [WB_ADR_WIDTH-1:0] BASE_ADR = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WB_ADR_WIDTH-1:0]           wb_adr,
    input  logic [DAT_WIDTH-1:0]              wb_dat_w,
    output logic [DAT_WIDTH-1:0]              wb_dat_r,
    input  logic                              wb_cyc,
    input  logic                              wb_stb,
    input  logic                              wb_we,
    input  logic [byte_lanes(DAT_WIDTH)-1:0]  wb_sel,
    output logic                              wb_ack,
    output logic                              wb_err,
    output logic [SRAM_ADR_WIDTH-1:0]         i_addr,
    output logic                              i_write_en,
    output logic [byte_lanes(DAT_WIDTH)-1:0]  i_byte_en,
    output logic [DAT_WIDTH-1:0]              i_write_data,
    input  logic [DAT_WIDTH-1:0]              i_read_data
);

    localparam int unsigned LANES = byte_lanes(DAT_WIDTH);

    wb2sram_state_e              state_q, state_d;
    logic [SRAM_ADR_WIDTH-1:0]   addr_q, addr_d;
    logic                        wen_q, wen_d;
    logic [LANES-1:0]            be_q, be_d;
    logic [DAT_WIDTH-1:0]        wdat_q, wdat_d;
    logic [DAT_WIDTH-1:0]        rdat_q, rdat_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic                        in_window;

`ifdef CLUSTERV_TILE_WB2SRAM_ERR_EN
    // Window is aligned to its size, so the decode is an upper-bit compare
    assign in_window = (wb_adr[WB_ADR_WIDTH-1:SRAM_ADR_WIDTH+2] ==
                        BASE_ADR[WB_ADR_WIDTH-1:SRAM_ADR_WIDTH+2]);
    logic adr_unused;
    assign adr_unused = ^wb_adr[1:0];
`else
    // Without decode the window aliases across the whole Wishbone space
    assign in_window = 1'b1;
    logic adr_unused;
    assign adr_unused = ^{wb_adr[WB_ADR_WIDTH-1:SRAM_ADR_WIDTH+2], wb_adr[1:0]};
`endif

    // Next-state and registered-output computation for the access sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    if (!in_window) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = wb_adr[SRAM_ADR_WIDTH+1:2];
                        be_d    = wb_sel;
                        wdat_d  = wb_dat_w;
                        wen_d   = wb_we;
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                // wen_q still holds the command type on the way out
                wen_d   = 1'b0;
                ack_d   = wen_q;
                state_d = wen_q ? RESP : RDATA;
            end
            RDATA: begin
                rdat_d  = i_read_data;
                ack_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign wb_ack       = ack_q;
    assign wb_err       = err_q;
    assign wb_dat_r     = rdat_q;
    assign i_addr       = addr_q;
    assign i_write_en   = wen_q;
    assign i_byte_en    = be_q;
    assign i_write_data = wdat_q;

endmodule

// File: tb/tb_clusterv_tile_wb2sram.sv
// Self-checking bench for clusterv_tile_wb2sram with a behavioural SRAM
// and a scoreboard of expected responses.
module tb_clusterv_tile_wb2sram;

`ifdef CLUSTERV_TILE_WB2SRAM_ERR_EN
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam bit          ERR_EN = 1'b1;
`else
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam bit          ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic        wb_ack;
    logic        wb_err;
    logic [7:0]  i_addr;
    logic        i_write_en;
    logic [3:0]  i_byte_en;
    logic [31:0] i_write_data;
    logic [31:0] i_read_data;

    always #5 clock = ~clock;

    clusterv_tile_wb2sram #(
        .WB_ADR_WIDTH   (32),
        .SRAM_ADR_WIDTH (8),
        .DAT_WIDTH      (32),
        .BASE_ADR       (BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_adr       (wb_adr),
        .wb_dat_w     (wb_dat_w),
        .wb_dat_r     (wb_dat_r),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_ack       (wb_ack),
        .wb_err       (wb_err),
        .i_addr       (i_addr),
        .i_write_en   (i_write_en),
        .i_byte_en    (i_byte_en),
        .i_write_data (i_write_data),
        .i_read_data  (i_read_data)
    );

    // Behavioural SRAM: byte-enable write, registered read
    logic [31:0] mem [256];
    logic [31:0] sram_rd = '0;
    assign i_read_data = sram_rd;
    always @(posedge clock) begin
        if (i_write_en)
            for (int b = 0; b < 4; b++)
                if (i_byte_en[b]) mem[i_addr][b*8 +: 8] <= i_write_data[b*8 +: 8];
        sram_rd <= mem[i_addr];
    end

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    int          checks = 0;
    int          failures = 0;
    int          ack_cnt = 0;
    int          we_pulses = 0;
    logic [31:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every ack/err
    always @(negedge clock) begin : mon
        exp_t e;
        if (i_write_en) we_pulses++;
        if (wb_ack || wb_err) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                check_eq("spurious_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("ack", wb_ack, !e.err);
                check_eq("err", wb_err, e.err);
                if (e.rd && !e.err) begin
                    check_eq("rdata", wb_dat_r, e.dat);
                    last_rd = e.dat;
                end else begin
                    check_eq("dat_hold", wb_dat_r, last_rd);
                end
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input bit drop_cyc);
        exp_t       e;
        int         n;
        int         a0;
        int         w0;
        int         exp_lat;
        logic [7:0] wi;
        logic       err;
        wi      = adr[9:2];
        err     = ERR_EN && (adr[31:10] != BASE[31:10]);
        exp_lat = err ? 1 : (we ? 2 : 3);
        e.rd    = !we;
        e.err   = err;
        e.dat   = ref_mem[wi];
        if (we && !err)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[wi][b*8 +: 8] = dat[b*8 +: 8];
        sb.push_back(e);
        a0 = ack_cnt;
        w0 = we_pulses;
        wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_sel = sel;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
            if (n == 1) begin
                check_eq("cmd_wen", i_write_en, we && !err);
                if (!err) begin
                    check_eq("cmd_addr", i_addr, wi);
                    check_eq("cmd_be", i_byte_en, sel);
                    if (we) check_eq("cmd_wdat", i_write_data, dat);
                end
                if (drop_cyc) begin
                    wb_cyc = 1'b0; wb_stb = 1'b0;
                end
            end
        end while (!(wb_ack || wb_err) && n < 12);
        check_eq("latency", n, exp_lat);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clock); #1;
        check_eq("ack_pulse", wb_ack | wb_err, 0);
        check_eq("ack_count", ack_cnt - a0, 1);
        check_eq("wen_pulses", we_pulses - w0, (we && !err) ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_eq("rst_ack", wb_ack, 0);
        check_eq("rst_err", wb_err, 0);
        check_eq("rst_dat_r", wb_dat_r, 0);
        check_eq("rst_addr", i_addr, 0);
        check_eq("rst_wen", i_write_en, 0);
        check_eq("rst_be", i_byte_en, 0);
        check_eq("rst_wdat", i_write_data, 0);
        check_eq("idle_wen_pulses", we_pulses, 0);

        // Full write then readback, then single-lane merge
        wb_xfer(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h10, 1'b1, 32'h0000AA00, 4'h2, 1'b0);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0);

        // Back-to-back at window edges
        wb_xfer(BASE + 32'h0,   1'b1, 32'h11111111, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h3FC, 1'b0, 32'h0, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h3FC, 1'b1, 32'h22222222, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h3FC, 1'b0, 32'h0, 4'hF, 1'b0);

        // Reset while a write sits in CMD: dropped, no ack, no SRAM write
        a0 = ack_cnt;
        wb_adr = BASE + 32'h20; wb_we = 1'b1; wb_dat_w = 32'h12345678; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clock); #1;
        check_eq("rst_cmd_wen", i_write_en, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_async_wen", i_write_en, 0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        last_rd = '0;
        @(posedge clock); #1;
        check_eq("rstcmd_ack", wb_ack, 0);
        check_eq("rstcmd_addr", i_addr, 0);
        check_eq("rstcmd_be", i_byte_en, 0);
        check_eq("rstcmd_wdat", i_write_data, 0);
        check_eq("rstcmd_dat_r", wb_dat_r, 0);
        reset = 1'b0;
        repeat (4) @(posedge clock); #1;
        check_eq("rstcmd_no_ack", ack_cnt - a0, 0);
        wb_xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 1'b0);

        // No-op write with no byte selects, low address bits ignored
        wb_xfer(BASE + 32'h3FF, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0);
        wb_xfer(BASE + 32'h3FD, 1'b0, 32'h0, 4'hF, 1'b0);

        // Master abandons the cycle after it was accepted
        wb_xfer(BASE + 32'h40, 1'b1, 32'hA5A55A5A, 4'hF, 1'b1);
        wb_xfer(BASE + 32'h40, 1'b0, 32'h0, 4'hF, 1'b0);

        // Outside the window: error with decode, alias to word 0 without
        wb_xfer(32'h2000, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0);
        wb_xfer(32'h2000, 1'b0, 32'h0, 4'hF, 1'b0);
        wb_xfer(BASE + 32'h0, 1'b0, 32'h0, 4'hF, 1'b0);

        // Mixed traffic within the window
        for (int i = 0; i < 16; i++) begin
            logic [31:0] adr;
            adr = BASE + ({$urandom_range(0, 255)} << 2) + {$urandom_range(0, 3)};
            wb_xfer(adr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
